// File: rtl/spi_master_frame.sv
// spi_master_frame: mode-0 SPI master sending one DATA_WIDTH frame MSB first and capturing the reply; ports clk_5kHz, rst, start, tx_data, rx_data, busy, done, mosi, miso, sclk, cs; define SPI_MASTER_LOOPBACK_EN to feed registered mosi back into the receiver
module spi_master_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int SCLK_HALF = 2
) (
  input  logic                  clk_5kHz,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs
);
  localparam int HW = SCLK_HALF > 1 ? $clog2(SCLK_HALF) : 1;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH} state_t;
  state_t state, state_n;
  logic [HW-1:0] hc, hc_n;
  logic [BW-1:0] bc, bc_n;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_n, tx_shl, rx_sh, rx_sh_n, rx_shl, rx_data_n;
  logic cs_n, sclk_n, mosi_n, busy_n, done_n, rx_in, last_bit;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_in = mosi;
`else
  assign rx_in = miso;
`endif
  assign tx_shl = tx_sh << 1;
  assign rx_shl = (rx_sh << 1) | DATA_WIDTH'(rx_in);
  assign last_bit = bc == BW'(DATA_WIDTH - 1);
  always_ff @(posedge clk_5kHz) begin
    if (rst) begin
      state <= IDLE;
      hc <= '0;
      bc <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      cs <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      hc <= hc_n;
      bc <= bc_n;
      tx_sh <= tx_sh_n;
      rx_sh <= rx_sh_n;
      rx_data <= rx_data_n;
      cs <= cs_n;
      sclk <= sclk_n;
      mosi <= mosi_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
  // FINISH is the done cycle; it already has busy=0, so it accepts start exactly like IDLE
  always_comb begin
    state_n = state;
    hc_n = hc == '0 ? HW'(SCLK_HALF - 1) : hc - 1'b1;
    bc_n = bc;
    tx_sh_n = tx_sh;
    rx_sh_n = rx_sh;
    rx_data_n = rx_data;
    cs_n = cs;
    sclk_n = sclk;
    mosi_n = mosi;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE, FINISH: begin
        state_n = start ? SETUP : IDLE;
        hc_n = HW'(SCLK_HALF - 1);
        if (start) begin
          tx_sh_n = tx_data;
          bc_n = '0;
          cs_n = 1'b0;
          mosi_n = tx_data[DATA_WIDTH-1];
          busy_n = 1'b1;
        end
      end
      SETUP, HIGH, LOW: begin
        if (hc == '0) begin
          if (state == HIGH) begin
            state_n = LOW;
            sclk_n = 1'b0;
            if (!last_bit) begin
              tx_sh_n = tx_shl;
              mosi_n = tx_shl[DATA_WIDTH-1];
            end
          end else if (state == LOW && last_bit) begin
            state_n = FINISH;
            cs_n = 1'b1;
            mosi_n = 1'b0;
            rx_data_n = rx_sh;
            done_n = 1'b1;
            busy_n = 1'b0;
          end else begin
            state_n = HIGH;
            sclk_n = 1'b1;
            rx_sh_n = rx_shl;
            bc_n = state == LOW ? bc + 1'b1 : bc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_master_frame.sv
// tb_spi_master_frame: randomized self-checking bench for spi_master_frame (default and 1-bit/1-cycle builds)
module tb_spi_master_frame;
  logic clk_5kHz = 0, rst = 1, start = 0, miso = 0;
  logic [7:0] tx_data = 0, rx_data;
  logic busy, done, mosi, sclk, cs;
  logic start1 = 0, miso1 = 1;
  logic [0:0] tx1 = 1, rx1;
  logic busy1, done1, mosi1, sclk1, cs1;
  int errors = 0, checks = 0;
  logic [7:0] resp = 0, mosi_bits = 0;
  int rises = 0, cs_low = 0, last_cs_low = 0, hi_cnt = 0, last_hi = 0, done_cnt = 0;
  logic prev_sclk = 0, prev_cs = 1;
  int c1 = 0, last1 = 0, r1 = 0;
  logic p1cs = 1, p1sclk = 0;

  spi_master_frame dut (.clk_5kHz(clk_5kHz), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs));
  spi_master_frame #(.DATA_WIDTH(1), .SCLK_HALF(1)) dut1 (.clk_5kHz(clk_5kHz), .rst(rst), .start(start1),
    .tx_data(tx1), .rx_data(rx1), .busy(busy1), .done(done1), .mosi(mosi1), .miso(miso1), .sclk(sclk1), .cs(cs1));

  always #5 clk_5kHz = ~clk_5kHz;

  // mode-0 responder and bus monitor: miso changes only away from rising clock edges
  always @(negedge clk_5kHz) begin
    if (!cs && prev_cs) begin
      rises = 0;
      cs_low = 0;
      mosi_bits = 0;
      last_hi = hi_cnt;
      miso = resp[7];
    end
    if (cs && !prev_cs) begin
      last_cs_low = cs_low;
      hi_cnt = 0;
    end
    if (!cs) cs_low++;
    else hi_cnt++;
    if (sclk && !prev_sclk) begin
      mosi_bits = {mosi_bits[6:0], mosi};
      rises++;
      miso = rises < 8 ? resp[7-rises] : 1'b0;
    end
    if (done) done_cnt++;
    prev_cs = cs;
    prev_sclk = sclk;
    if (!cs1 && p1cs) begin
      c1 = 0;
      r1 = 0;
    end
    if (cs1 && !p1cs) last1 = c1;
    if (!cs1) c1++;
    if (sclk1 && !p1sclk) r1++;
    p1cs = cs1;
    p1sclk = sclk1;
  end

  task automatic tick();
    @(negedge clk_5kHz);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  function automatic logic [7:0] expect_rx(input logic [7:0] tx, input logic [7:0] r);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return r;
`endif
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b want=1", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b want=0", mosi); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx got=%h want=00", rx_data); end
    rst = 0;
    tick();
  endtask

  task automatic test_frames(input int n, input bit fixed);
    bit ok;
    logic [7:0] tx, r;
    for (int k = 0; k < n; k++) begin
      tx = fixed ? 8'hA5 : 8'($urandom);
      r = fixed ? 8'h3C : 8'($urandom);
      resp = r;
      tx_data = tx;
      start = 1;
      tick();
      start = 0;
      tx_data = ~tx;
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got=no_done want=done"); end
      checks++; if (rx_data !== expect_rx(tx, r)) begin errors++; $display("FAIL frame_rx got=%h want=%h", rx_data, expect_rx(tx, r)); end
      checks++; if (mosi_bits !== tx) begin errors++; $display("FAIL frame_mosi got=%h want=%h", mosi_bits, tx); end
      checks++; if (rises !== 8) begin errors++; $display("FAIL frame_rises got=%0d want=8", rises); end
      checks++; if (last_cs_low !== 34) begin errors++; $display("FAIL frame_cs_low got=%0d want=34", last_cs_low); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_at_done got=%b want=0", busy); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL frame_done_width got=%b want=0", done); end
      repeat (2) tick();
    end
  endtask

  task automatic test_ignore_start();
    int d0, seen;
    bit busy_ok;
    d0 = done_cnt;
    busy_ok = 1;
    seen = 0;
    resp = 8'h96;
    tx_data = 8'h3B;
    start = 1;
    tick();
    start = 0;
    for (int i = 1; i < 120 && seen == 0; i++) begin
      start = (i == 10);
      tick();
      if (done) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    start = 0;
    repeat (50) tick();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt - d0); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL ignore_busy got=dropped want=continuous"); end
    checks++; if (rx_data !== expect_rx(8'h3B, 8'h96)) begin errors++; $display("FAIL ignore_rx got=%h want=%h", rx_data, expect_rx(8'h3B, 8'h96)); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] y;
    y = 8'($urandom);
    resp = 8'h81;
    tx_data = 8'hC3;
    start = 1;
    wait_done(ok);
    tx_data = y;
    tick();
    start = 0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got=no_done want=done"); end
    checks++; if (last_hi !== 1) begin errors++; $display("FAIL b2b_cs_high got=%0d want=1", last_hi); end
    checks++; if (mosi_bits !== y) begin errors++; $display("FAIL b2b_relatch got=%h want=%h", mosi_bits, y); end
    checks++; if (rx_data !== expect_rx(y, 8'h81)) begin errors++; $display("FAIL b2b_rx got=%h want=%h", rx_data, expect_rx(y, 8'h81)); end
    repeat (3) tick();
  endtask

  task automatic test_abort();
    int d0;
    resp = 8'hFF;
    tx_data = 8'hFF;
    start = 1;
    tick();
    start = 0;
    repeat (14) tick();
    rst = 1;
    tick();
    checks++; if ({cs, sclk, mosi} !== 3'b100) begin errors++; $display("FAIL abort_bus got=%b want=100", {cs, sclk, mosi}); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_busy_done got=%b want=00", {busy, done}); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx got=%h want=00", rx_data); end
    rst = 0;
    d0 = done_cnt;
    repeat (60) tick();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got=%0d want=%0d", done_cnt, d0); end
  endtask

  task automatic test_width1();
    bit ok;
    ok = 0;
    tx1 = 1'b1;
    start1 = 1;
    tick();
    start1 = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (done1) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL w1_timeout got=no_done want=done"); end
    checks++; if (rx1 !== 1'b1) begin errors++; $display("FAIL w1_rx got=%b want=1", rx1); end
    checks++; if (last1 !== 3) begin errors++; $display("FAIL w1_cs_low got=%0d want=3", last1); end
    checks++; if (r1 !== 1) begin errors++; $display("FAIL w1_rises got=%0d want=1", r1); end
  endtask

  initial begin
    test_reset();
    test_frames(1, 1);
    test_frames(5, 0);
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
